aes_round_sequencer: RTL

Iterative AES round controller that sequences the shared round datapath (SubBytes/ShiftRows, MixColumn with its forward and inverse outputs, AddRoundKey) over one block at a time. It accepts a block request over a valid/ready handshake and fetches round keys from the key schedule over a request/valid handshake. It issues per-cycle load and select strobes to the datapath, and presents completion over a second valid/ready handshake. The datapath registers and the key schedule are external; this block holds only sequencing state.

---
 rtl/aes_round_sequencer_if.sv | 31 +++
 rtl/aes_round_sequencer.sv | 102 ++++++++++
 2 files changed

// File: rtl/aes_round_sequencer_if.sv
// Handshake and datapath-control bundle between the AES round sequencer and its environment.
// The sequencer uses the slave modport; the requester/datapath side uses master.
interface aes_round_sequencer_if;
    logic       in_valid;
    logic       in_decrypt;
    logic       in_ready;
    logic       key_req;
    logic [3:0] key_round;
    logic       key_valid;
    logic       dp_load_init;
    logic       dp_load_round;
    logic       mix_en;
    logic       mix_inv;
    logic       sub_inv;
    logic [3:0] round;
    logic       busy;
    logic       out_valid;
    logic       out_ready;

    modport slave (
        input  in_valid, in_decrypt, key_valid, out_ready,
        output in_ready, key_req, key_round, dp_load_init, dp_load_round,
               mix_en, mix_inv, sub_inv, round, busy, out_valid
    );

    modport master (
        output in_valid, in_decrypt, key_valid, out_ready,
        input  in_ready, key_req, key_round, dp_load_init, dp_load_round,
               mix_en, mix_inv, sub_inv, round, busy, out_valid
    );
endinterface

// File: rtl/aes_round_sequencer.sv
// Iterative AES round controller: sequences initial AddRoundKey, NR-1 full rounds and the
// final round over an external datapath, fetching one round key per load.
module aes_round_sequencer #(
    parameter int unsigned NR = 10
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_clear,
    aes_round_sequencer_if.slave   bus
);
    localparam logic [3:0] NrW = 4'(NR);

    typedef enum logic [2:0] {StIdle, StInit, StRound, StFinal, StDone} state_t;

    state_t     r_state;
    logic [3:0] r_round;
    logic       r_dec;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
            r_round <= 4'd0;
            r_dec   <= 1'b0;
        end else if (i_clear) begin
            r_state <= StIdle;
            r_round <= 4'd0;
            r_dec   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (bus.in_valid) begin
                        r_dec   <= bus.in_decrypt;
                        r_round <= 4'd0;
                        r_state <= StInit;
                    end
                end
                StInit: begin
                    if (bus.key_valid) begin
                        r_round <= 4'd1;
                        r_state <= StRound;
                    end
                end
                StRound: begin
                    if (bus.key_valid) begin
                        r_round <= r_round + 4'd1;
                        if (r_round == NrW - 4'd1) begin
                            r_state <= StFinal;
                        end
                    end
                end
                StFinal: begin
                    if (bus.key_valid) begin
                        r_state <= StDone;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        r_round <= 4'd0;
                        r_dec   <= 1'b0;
                        r_state <= StIdle;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_round <= 4'd0;
                    r_dec   <= 1'b0;
                end
            endcase
        end
    end

    logic w_idle;
    logic w_key_phase;
    logic [3:0] w_key_round;

    assign w_idle      = (r_state == StIdle);
    assign w_key_phase = (r_state == StInit) || (r_state == StRound) || (r_state == StFinal);

    // Decryption walks the key schedule backwards: NR down to 0.
    always_comb begin
        w_key_round = 4'd0;
        unique case (r_state)
            StInit:  w_key_round = r_dec ? NrW : 4'd0;
            StRound: w_key_round = r_dec ? (NrW - r_round) : r_round;
            StFinal: w_key_round = r_dec ? 4'd0 : NrW;
            default: w_key_round = 4'd0;
        endcase
    end

    assign bus.in_ready      = w_idle;
    assign bus.busy          = !w_idle;
    assign bus.key_req       = w_key_phase;
    assign bus.key_round     = w_key_round;
    assign bus.round         = r_round;
    assign bus.mix_en        = (r_state == StRound);
    assign bus.mix_inv       = r_dec && !w_idle;
    assign bus.sub_inv       = r_dec && !w_idle;
    assign bus.out_valid     = (r_state == StDone);
    assign bus.dp_load_init  = (r_state == StInit) && bus.key_valid && !i_clear;
    assign bus.dp_load_round = ((r_state == StRound) || (r_state == StFinal))
                               && bus.key_valid && !i_clear;
endmodule
